// File: rtl/fetch_exec_ctrl_pkg.sv
// Shared types for the Nibbler fetch/execute controller: opcode map, ALU select,
// the decoded strobe bundle and instruction-word field positions.
package nibbler_pkg;

  typedef enum logic [3:0] {
    OP_JC   = 4'h0,
    OP_JNC  = 4'h1,
    OP_CMPI = 4'h2,
    OP_CMPM = 4'h3,
    OP_LIT  = 4'h4,
    OP_IN   = 4'h5,
    OP_LD   = 4'h6,
    OP_ST   = 4'h7,
    OP_JZ   = 4'h8,
    OP_JNZ  = 4'h9,
    OP_ADDI = 4'hA,
    OP_ADDM = 4'hB,
    OP_JMP  = 4'hC,
    OP_OUT  = 4'hD,
    OP_NORI = 4'hE,
    OP_NORM = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_PASS_B = 3'd0,
    ALU_ADD    = 3'd1,
    ALU_SUB    = 3'd2,
    ALU_NOR    = 3'd3
  } alu_op_t;

  typedef struct packed {
    alu_op_t alu_op;
    logic    ld_acc;
    logic    ld_flags;
    logic    ram_we;
    logic    ram_oe;
    logic    out_we;
    logic    in_oe;
  } strobe_t;

  localparam int IR_W      = 16;
  localparam int IR_OP_HI  = 15;
  localparam int IR_OP_LO  = 12;
  localparam int IR_IMM_HI = 11;
  localparam int IR_IMM_LO = 8;

endpackage

// File: rtl/fetch_exec_ctrl_if.sv
// Controller-facing bundle: phase/ROM/flag inputs and the pc, ir and strobe outputs.
// master = the controller, slave = the datapath/phase-generator side.
interface fetch_exec_ctrl_if #(
  parameter int PC_W = 12
);
  import nibbler_pkg::*;

  logic              phase;
  logic [IR_W-1:0]   instr;
  logic              carry;
  logic              zero;
  logic [PC_W-1:0]   pc;
  logic [IR_W-1:0]   ir;
  logic [3:0]        imm;
  alu_op_t           alu_op;
  logic              ld_acc;
  logic              ld_flags;
  logic              ram_we;
  logic              ram_oe;
  logic              out_we;
  logic              in_oe;
  logic              phase_err;

  modport master (
    input  phase, instr, carry, zero,
    output pc, ir, imm, alu_op, ld_acc, ld_flags, ram_we, ram_oe, out_we, in_oe, phase_err
  );

  modport slave (
    output phase, instr, carry, zero,
    input  pc, ir, imm, alu_op, ld_acc, ld_flags, ram_we, ram_oe, out_we, in_oe, phase_err
  );

endinterface

// File: rtl/fetch_exec_ctrl_instr_decoder.sv
// Combinational opcode decode: datapath strobes plus the jump-taken bit.
// Output is ungated; the controller masks it outside an active execute cycle.
module instr_decoder
  import nibbler_pkg::*;
(
  input  opcode_t opcode,
  input  logic    carry,
  input  logic    zero,
  output strobe_t strb,
  output logic    taken
);

  always_comb begin
    strb  = '0;
    taken = 1'b0;
    case (opcode)
      OP_JC:   taken = carry;
      OP_JNC:  taken = ~carry;
      OP_JZ:   taken = zero;
      OP_JNZ:  taken = ~zero;
      OP_JMP:  taken = 1'b1;
      OP_CMPI: begin
        strb.alu_op   = ALU_SUB;
        strb.ld_flags = 1'b1;
      end
      OP_CMPM: begin
        strb.alu_op   = ALU_SUB;
        strb.ld_flags = 1'b1;
        strb.ram_oe   = 1'b1;
      end
      OP_LIT: begin
        strb.alu_op = ALU_PASS_B;
        strb.ld_acc = 1'b1;
      end
      OP_IN: begin
        strb.in_oe  = 1'b1;
        strb.ld_acc = 1'b1;
      end
      OP_LD: begin
        strb.ram_oe = 1'b1;
        strb.ld_acc = 1'b1;
      end
      OP_ST:   strb.ram_we = 1'b1;
      OP_ADDI: begin
        strb.alu_op   = ALU_ADD;
        strb.ld_acc   = 1'b1;
        strb.ld_flags = 1'b1;
      end
      OP_ADDM: begin
        strb.alu_op   = ALU_ADD;
        strb.ld_acc   = 1'b1;
        strb.ld_flags = 1'b1;
        strb.ram_oe   = 1'b1;
      end
      OP_OUT:  strb.out_we = 1'b1;
      OP_NORI: begin
        strb.alu_op   = ALU_NOR;
        strb.ld_acc   = 1'b1;
        strb.ld_flags = 1'b1;
      end
      OP_NORM: begin
        strb.alu_op   = ALU_NOR;
        strb.ld_acc   = 1'b1;
        strb.ld_flags = 1'b1;
        strb.ram_oe   = 1'b1;
      end
      default: begin
        strb  = '0;
        taken = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fetch_exec_ctrl.sv
// Two-phase Nibbler controller: latches ir on fetch, strobes and advances pc on execute.
// A phase that fails to alternate sets a sticky error that freezes pc/ir and masks strobes.
module fetch_exec_ctrl
  import nibbler_pkg::*;
#(
  parameter int              PC_W     = 12,
  parameter logic [PC_W-1:0] RESET_PC = 12'h000
) (
  input  logic               clk,
  input  logic               reset,
  fetch_exec_ctrl_if.master  bus
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic            exp_phase_q, exp_phase_d;
  logic            phase_err_q, phase_err_d;

  opcode_t opcode;
  strobe_t dec_strb;
  strobe_t strb;
  logic    dec_taken;
  logic    exec_active;

  assign opcode = opcode_t'(ir_q[IR_OP_HI:IR_OP_LO]);

  instr_decoder u_instr_decoder (
    .opcode (opcode),
    .carry  (bus.carry),
    .zero   (bus.zero),
    .strb   (dec_strb),
    .taken  (dec_taken)
  );

  // Reset is included so strobes drop the instant reset asserts, not at the next edge.
  assign exec_active = reset & bus.phase & ~phase_err_q;

  always_comb begin
    pc_d        = pc_q;
    ir_d        = ir_q;
    exp_phase_d = ~bus.phase;
    phase_err_d = phase_err_q | (bus.phase != exp_phase_q);
    strb        = '0;

    if (!phase_err_q) begin
      if (bus.phase) begin
        pc_d = dec_taken ? ir_q[PC_W-1:0] : pc_q + PC_W'(1);
      end else begin
        ir_d = bus.instr;
      end
    end

    if (exec_active) begin
      strb = dec_strb;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      exp_phase_q <= 1'b0;
      phase_err_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      exp_phase_q <= exp_phase_d;
      phase_err_q <= phase_err_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.ir        = ir_q;
  assign bus.imm       = ir_q[IR_IMM_HI:IR_IMM_LO];
  assign bus.alu_op    = strb.alu_op;
  assign bus.ld_acc    = strb.ld_acc;
  assign bus.ld_flags  = strb.ld_flags;
  assign bus.ram_we    = strb.ram_we;
  assign bus.ram_oe    = strb.ram_oe;
  assign bus.out_we    = strb.out_we;
  assign bus.in_oe     = strb.in_oe;
  assign bus.phase_err = phase_err_q;

endmodule

// File: tb/tb_fetch_exec_ctrl.sv
// Randomized bench for fetch_exec_ctrl against an instruction-level reference model,
// with literal pins on the directed scenarios.
module tb_fetch_exec_ctrl;
  import nibbler_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        ph    = 1'b0;
  logic [15:0] ins   = 16'h0000;
  logic        c     = 1'b0;
  logic        z     = 1'b0;

  fetch_exec_ctrl_if #(.PC_W(12)) bus ();

  assign bus.phase = ph;
  assign bus.instr = ins;
  assign bus.carry = c;
  assign bus.zero  = z;

  fetch_exec_ctrl #(.PC_W(12), .RESET_PC(12'h000)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          m_pc;
  logic [15:0] m_ir;
  logic        m_exp;
  logic        m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {alu_op[2:0], ld_acc, ld_flags, ram_we, ram_oe, out_we, in_oe} straight from the opcode table
  function automatic logic [8:0] exp_strb(input logic [3:0] op);
    case (op)
      4'h2:    return {3'd2, 6'b010000};
      4'h3:    return {3'd2, 6'b010100};
      4'h4:    return {3'd0, 6'b100000};
      4'h5:    return {3'd0, 6'b100001};
      4'h6:    return {3'd0, 6'b100100};
      4'h7:    return {3'd0, 6'b001000};
      4'hA:    return {3'd1, 6'b110000};
      4'hB:    return {3'd1, 6'b110100};
      4'hD:    return {3'd0, 6'b000010};
      4'hE:    return {3'd3, 6'b110000};
      4'hF:    return {3'd3, 6'b110100};
      default: return 9'h000;
    endcase
  endfunction

  function automatic bit jump_taken(input logic [3:0] op, input logic cy, input logic zr);
    return (op == 4'h0 && cy) || (op == 4'h1 && !cy) || (op == 4'h8 && zr) ||
           (op == 4'h9 && !zr) || (op == 4'hC);
  endfunction

  task automatic model_reset();
    m_pc  = 0;
    m_ir  = 16'h0000;
    m_exp = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic check_outputs();
    logic [8:0] e;
    e = (rst_n && ph && !m_err) ? exp_strb(m_ir[15:12]) : 9'h000;
    chk("pc",        32'(bus.pc),        32'(m_pc));
    chk("ir",        32'(bus.ir),        32'(m_ir));
    chk("imm",       32'(bus.imm),       32'(m_ir[11:8]));
    chk("alu_op",    32'(bus.alu_op),    32'(e[8:6]));
    chk("ld_acc",    32'(bus.ld_acc),    32'(e[5]));
    chk("ld_flags",  32'(bus.ld_flags),  32'(e[4]));
    chk("ram_we",    32'(bus.ram_we),    32'(e[3]));
    chk("ram_oe",    32'(bus.ram_oe),    32'(e[2]));
    chk("out_we",    32'(bus.out_we),    32'(e[1]));
    chk("in_oe",     32'(bus.in_oe),     32'(e[0]));
    chk("phase_err", 32'(bus.phase_err), 32'(m_err));
  endtask

  // Drive inputs just after a rising edge, then compare at the falling edge.
  task automatic apply(input logic p, input logic [15:0] i, input logic cy, input logic zr);
    ph  = p;
    ins = i;
    c   = cy;
    z   = zr;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic step();
    bit mism;
    @(posedge clk);
    if (rst_n) begin
      mism = (ph != m_exp);
      if (!m_err) begin
        if (ph) m_pc = jump_taken(m_ir[15:12], c, z) ? int'(m_ir[11:0]) : (m_pc + 1) % 4096;
        else    m_ir = ins;
      end
      m_exp = ~ph;
      if (mism) m_err = 1'b1;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ph    = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic do_instr(input logic [15:0] i, input logic cy, input logic zr);
    apply(1'b0, i, cy, zr);
    step();
    apply(1'b1, 16'($urandom), cy, zr);
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    do_reset();
    chk("reset_pc", 32'(bus.pc), 32'h000);
    chk("reset_ir", 32'(bus.ir), 32'h0000);

    // LIT 0xA
    apply(1'b0, 16'h4A00, 1'b0, 1'b0);
    step();
    chk("lit_ir", 32'(bus.ir), 32'h4A00);
    apply(1'b1, 16'h0000, 1'b0, 1'b0);
    chk("lit_ld_acc", 32'(bus.ld_acc), 32'd1);
    chk("lit_alu",    32'(bus.alu_op), 32'd0);
    chk("lit_imm",    32'(bus.imm),    32'hA);
    step();
    chk("lit_pc", 32'(bus.pc), 32'h001);

    // JC taken then not taken
    do_instr(16'h0123, 1'b1, 1'b0);
    chk("jc_taken_pc", 32'(bus.pc), 32'h123);
    do_instr(16'h0123, 1'b0, 1'b0);
    chk("jc_nt_pc", 32'(bus.pc), 32'h124);

    // ST strobe only during execute
    apply(1'b0, 16'h7045, 1'b0, 1'b0);
    chk("st_fetch_we", 32'(bus.ram_we), 32'd0);
    step();
    apply(1'b1, 16'h0000, 1'b0, 1'b0);
    chk("st_exec_we", 32'(bus.ram_we), 32'd1);
    step();
    chk("st_pc", 32'(bus.pc), 32'h125);

    // PC wrap
    do_instr(16'hCFFF, 1'b0, 1'b0);
    chk("jmp_pc", 32'(bus.pc), 32'hFFF);
    do_instr(16'h4100, 1'b0, 1'b0);
    chk("wrap_pc", 32'(bus.pc), 32'h000);

    for (int k = 0; k < 300; k++)
      do_instr(16'($urandom), 1'($urandom), 1'($urandom));

    // Phase held at fetch for two cycles
    do_reset();
    apply(1'b0, 16'h4500, 1'b0, 1'b0);
    step();
    apply(1'b0, 16'h4500, 1'b0, 1'b0);
    step();
    chk("perr_set", 32'(bus.phase_err), 32'd1);
    for (int k = 0; k < 12; k++) begin
      apply(1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      step();
    end
    chk("perr_pc_frozen", 32'(bus.pc), 32'h000);
    chk("perr_ir_frozen", 32'(bus.ir), 32'h4500);
    chk("perr_sticky",    32'(bus.phase_err), 32'd1);
    do_reset();
    chk("perr_cleared", 32'(bus.phase_err), 32'd0);
    chk("perr_rst_pc",  32'(bus.pc), 32'h000);

    // Mostly-correct phase with occasional violations and periodic resets
    for (int k = 0; k < 400; k++) begin
      if (k % 80 == 79) do_reset();
      apply(($urandom_range(0, 15) == 0) ? ~m_exp : m_exp,
            16'($urandom), 1'($urandom), 1'($urandom));
      step();
    end

    // Reset asserted in the middle of an ADDI execute
    do_reset();
    apply(1'b0, 16'hA300, 1'b0, 1'b0);
    step();
    apply(1'b1, 16'h0000, 1'b0, 1'b0);
    chk("addi_ld_acc",   32'(bus.ld_acc),   32'd1);
    chk("addi_ld_flags", 32'(bus.ld_flags), 32'd1);
    chk("addi_alu",      32'(bus.alu_op),   32'd1);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_ld_acc",   32'(bus.ld_acc),   32'd0);
    chk("midrst_ld_flags", 32'(bus.ld_flags), 32'd0);
    chk("midrst_pc",       32'(bus.pc),       32'h000);
    chk("midrst_ir",       32'(bus.ir),       32'h0000);
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(1'b0, 16'h4500, 1'b0, 1'b0);
    step();
    chk("post_rst_fetch_ir", 32'(bus.ir), 32'h4500);
    chk("post_rst_no_err",   32'(bus.phase_err), 32'd0);
    apply(1'b1, 16'h0000, 1'b0, 1'b0);
    chk("post_rst_ld_acc", 32'(bus.ld_acc), 32'd1);
    step();
    chk("post_rst_pc", 32'(bus.pc), 32'h001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_exec_ctrl.md
# fetch_exec_ctrl

Two-phase fetch/execute controller for the Nibbler 4-bit CPU, on the consuming end of the phase signal produced by the phase generator. On each fetch phase it latches the 16-bit instruction word addressed by its program counter. On each execute phase it decodes that word into datapath strobes and updates the 12-bit PC. It also checks that the incoming phase strictly alternates, and locks out all strobes on a protocol violation.

## Interface
Parameters:
- PC_W, 12, program counter / ROM address width
- RESET_PC, 12'h000, PC value after reset

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- phase  in  1  from phase generator; 0 = fetch, 1 = execute
- instr  in  16  ROM data at address pc: [15:12] opcode, [11:8] immediate, [11:0] jump target
- carry  in  1  ALU carry flag from flags register
- zero  in  1  ALU zero flag from flags register
- pc  out  12  program counter, drives ROM address
- ir  out  16  instruction register
- imm  out  4  ir[11:8]
- alu_op  out  3  ALU function select (enum from package)
- ld_acc  out  1  load accumulator
- ld_flags  out  1  load carry/zero register
- ram_we  out  1  data RAM write enable (ST)
- ram_oe  out  1  data RAM read enable (LD, ADDM, CMPM, NORM)
- out_we  out  1  output port load (OUT)
- in_oe  out  1  input port drive (IN)
- phase_err  out  1  sticky phase-protocol violation flag

## Operation
- Reset (reset=0, async): pc=RESET_PC, ir=16'h0000, exp_phase=0, phase_err=0. All strobes are 0 while reset is low.
- Fetch (phase=0): all strobes are 0. At the closing edge, ir <= instr and exp_phase <= 1.
- Execute (phase=1): strobes decode combinationally from ir, gated by phase & ~phase_err. At the closing edge, pc <= taken ? ir[11:0] : pc+1 and exp_phase <= 0.
- Opcode map (nibbler_pkg):
  - 0 JC and 1 JNC: jump on carry / not carry.
  - 2 CMPI and 3 CMPM: alu_op=SUB, ld_flags only.
  - 4 LIT: alu_op=PASS_B, ld_acc.
  - 5 IN: in_oe, ld_acc.
  - 6 LD: ram_oe, ld_acc.
  - 7 ST: ram_we.
  - 8 JZ and 9 JNZ: jump on zero / not zero.
  - A ADDI and B ADDM: alu_op=ADD, ld_acc, ld_flags.
  - C JMP: unconditional jump.
  - D OUT: out_we.
  - E NORI and F NORM: alu_op=NOR, ld_acc, ld_flags.
  - The M variants also assert ram_oe at RAM address ir[11:0]; the I variants use imm.
- Jump condition: carry and zero are sampled during execute. A not-taken jump increments pc.
- PC arithmetic: 12-bit modulo, so 12'hFFF+1 wraps to 12'h000.
- Phase checker: if phase != exp_phase on any rising edge, phase_err <= 1. The error is sticky until reset.
  - While phase_err=1: strobes are forced to 0, pc and ir hold, and exp_phase keeps following phase so no further state changes occur.
- Reset mid-execute: strobes drop immediately (combinational gating on reset) and no pc update occurs.

## Timing
- Each instruction takes 2 clocks: one fetch, one execute. The first fetch occurs in the first cycle after reset release.
- ROM is combinational. instr must be valid within the fetch cycle for the current pc.
- Strobes are valid for exactly the execute cycle. The datapath samples them at the rising edge ending execute.
- pc changes only at the end of execute, so it is stable across the following fetch.
- phase_err asserts at the first rising edge where the mismatch is sampled. Strobes are gated from the next cycle on.

## Structure
- nibbler_pkg holds:
  - opcode_t enum (16 values above)
  - alu_op_t enum: PASS_B, ADD, SUB, NOR
  - the ir field position constants
- Sub-module instr_decoder is purely combinational. It maps opcode, carry and zero to the strobe bundle and a taken bit.
- fetch_exec_ctrl contains pc, ir, exp_phase and phase_err, plus the gating logic.

## Test plan
- Reset, then drive alternating phase with instr=16'h4A00 (LIT 0xA): ir=16'h4A00 after fetch; during execute ld_acc=1, alu_op=PASS_B, imm=4'hA; pc goes 0 to 1.
- JC with carry=1, instr=16'h0123: pc=12'h123 after execute. Repeat with carry=0: pc=previous+1.
- ST with instr=16'h7045: ram_we=1 only in the execute cycle and 0 during fetch; pc increments.
- Set pc=12'hFFF via JMP 16'hCFFF, then execute a non-jump: pc wraps to 12'h000.
- Hold phase=0 for two consecutive cycles: phase_err=1, all strobes 0 thereafter, pc and ir frozen. Assert reset: phase_err=0 and pc=0.
- Pull reset low during an execute cycle of ADDI: strobes drop to 0 immediately, pc=0 and ir=0, first post-release cycle is fetch.
